// File: rtl/pwm_audio_multi_out_if.sv
// Frame handshake between the audio sample source and the PWM output stage.
// Signals:
//   sample        CHANNELS*WIDTH frame, channel i at [i*WIDTH +: WIDTH]
//   sample_valid  frame present on sample
//   sample_ready  output stage can take a frame this cycle
// Modports: master (sample source), slave (PWM output stage).
interface pwm_audio_multi_out_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) ();
    logic [CHANNELS*WIDTH-1:0] sample;
    logic                      sample_valid;
    logic                      sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/pwm_audio_multi_out.sv
// Multi-channel PWM audio output stage with a one-frame shadow buffer.
// A frame is accepted over the bus handshake into the shadow buffer and is
// swapped into the active duty registers only at a PWM period boundary, so a
// duty never changes mid-period. Boundaries with no pending frame repeat the
// last frame and are reported as underruns.
// Ports:
//   clk             system clock, rising edge
//   aclr_n          synchronous active-low reset
//   bus             slave side of pwm_audio_multi_out_if (sample/valid/ready)
//   pwm_out         registered PWM pins, one per channel
//   period_start    one-clock pulse at each period boundary
//   underrun        one-clock pulse at a boundary with an empty shadow buffer
//   underrun_count  saturating count of underrun pulses
// Optional feature: define PWM_AUDIO_SIGNED_INPUT_EN to treat each channel as
// two's complement (MSB inverted at accept, giving offset binary duty).
module pwm_audio_multi_out #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                aclr_n,
    pwm_audio_multi_out_if.slave bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                underrun,
    output logic [15:0]         underrun_count
);
    localparam int unsigned FRAME_W = CHANNELS * WIDTH;
    localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CNT_W   = 16;

    logic [PRE_W-1:0]   pre_q;
    logic [WIDTH-1:0]   cnt_q;
    logic [FRAME_W-1:0] shadow_q;
    logic [FRAME_W-1:0] active_q;
    logic [FRAME_W-1:0] sample_conv;
    logic               shadow_full_q;
    logic               shadow_full_d;
    logic               ready_q;
    logic               tick;
    logic               boundary;
    logic               accept;

    assign tick     = (pre_q == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (cnt_q == {WIDTH{1'b1}});
    assign accept   = bus.sample_valid && ready_q;

    // ready is a registered copy of !shadow_full, forced low while in reset
    assign bus.sample_ready = ready_q;

    // Shadow load value; signed input becomes offset binary by flipping each MSB
    always_comb begin
        sample_conv = bus.sample;
`ifdef PWM_AUDIO_SIGNED_INPUT_EN
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sample_conv[i*WIDTH + WIDTH - 1] = ~bus.sample[i*WIDTH + WIDTH - 1];
        end
`else
`endif
    end

    // Boundary drains the shadow using its pre-edge state; a same-cycle accept refills it
    always_comb begin
        shadow_full_d = shadow_full_q;
        if (boundary) begin
            shadow_full_d = 1'b0;
        end
        if (accept) begin
            shadow_full_d = 1'b1;
        end
    end

    // Prescaler, tick counter, double buffer, underrun tracking and compare
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            shadow_full_q  <= 1'b0;
            ready_q        <= 1'b0;
            pwm_out        <= '0;
            period_start   <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                cnt_q <= cnt_q + WIDTH'(1);
            end
            shadow_full_q <= shadow_full_d;
            ready_q       <= ~shadow_full_d;
            if (accept) begin
                shadow_q <= sample_conv;
            end
            if (boundary && shadow_full_q) begin
                active_q <= shadow_q;
            end
            period_start <= boundary;
            underrun     <= boundary && !shadow_full_q;
            if (boundary && !shadow_full_q && (underrun_count != {CNT_W{1'b1}})) begin
                underrun_count <= underrun_count + CNT_W'(1);
            end
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pwm_out[i] <= (cnt_q < active_q[i*WIDTH +: WIDTH]);
            end
        end
    end
endmodule
